// File: rtl/fp32_to_int32_seq.sv
// fp32_to_int32_seq: multi-cycle FP32 -> signed int32 converter with valid/ready handshakes.
// Unpacks the operand, aligns the 24-bit significand with an iterative right shifter
// (SHIFT_STEP bits per cycle), then rounds, applies the sign and holds the result until taken.
// Out-of-range, NaN and Inf inputs saturate and raise out_invalid; discarded fraction bits
// raise out_inexact.
// Optional build macro: FP2INT_ROUND_NEAREST_EN selects round-to-nearest-even; when it is
// undefined the magnitude is truncated toward zero.
module fp32_to_int32_seq #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam logic [4:0] StepW = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {StIdle, StAlign, StFinish, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  rem_q, rem_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic        spec_inv_q, spec_inv_d;
  logic [31:0] res_q, res_d;
  logic        inv_q, inv_d;
  logic        inex_q, inex_d;

  logic        accept;
  logic [7:0]  exp_w;
  logic [23:0] sig_w;
  logic        dec_spec, dec_inv, dec_sticky;
  logic [31:0] dec_val, dec_mag;
  logic [4:0]  dec_rem;
  logic [4:0]  amt;
  logic [31:0] sh_mag;
  logic        sh_guard, sh_sticky;
  logic        inc;
  logic [31:0] rnd_mag;

  assign accept = (state_q == StIdle) && in_valid;
  assign exp_w  = in_data[30:23];
  assign sig_w  = {1'b1, in_data[22:0]};

  // Classify the incoming operand and prepare the initial alignment state.
  always_comb begin
    dec_spec   = 1'b0;
    dec_inv    = 1'b0;
    dec_val    = 32'h0;
    dec_mag    = 32'h0;
    dec_sticky = 1'b0;
    dec_rem    = 5'd0;
    if (exp_w == 8'd255) begin
      dec_spec = 1'b1;
      dec_inv  = 1'b1;
      // NaN always maps to the positive limit regardless of sign.
      dec_val  = (in_data[31] && (in_data[22:0] == 23'h0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (exp_w >= 8'd158) begin
      dec_spec = 1'b1;
      if (in_data == 32'hCF00_0000) begin
        // -2^31 is exactly representable.
        dec_val = 32'h8000_0000;
      end else begin
        dec_inv = 1'b1;
        dec_val = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (exp_w < 8'd126) begin
      dec_sticky = (in_data[30:0] != 31'h0);
    end else if (exp_w >= 8'd150) begin
      dec_mag = {8'h0, sig_w} << (exp_w - 8'd150);
    end else begin
      dec_mag = {8'h0, sig_w};
      dec_rem = 5'(8'd150 - exp_w);
    end
  end

  // One ALIGN step: shift right by min(SHIFT_STEP, remaining), folding lost bits into guard/sticky.
  always_comb begin
    amt       = (rem_q < StepW) ? rem_q : StepW;
    sh_mag    = mag_q;
    sh_guard  = guard_q;
    sh_sticky = sticky_q;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (5'(i) < amt) begin
        sh_sticky = sh_sticky | sh_guard;
        sh_guard  = sh_mag[0];
        sh_mag    = sh_mag >> 1;
      end
    end
  end

  // Rounding increment; the magnitude stays below 2^31 so the add cannot overflow.
  always_comb begin
`ifdef FP2INT_ROUND_NEAREST_EN
    inc = guard_q & (sticky_q | mag_q[0]);
`else
    inc = 1'b0;
`endif
    rnd_mag = mag_q + {31'h0, inc};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = (dec_rem != 5'd0) ? StAlign : StFinish;
      StAlign:  if (rem_q == amt) state_d = StFinish;
      StFinish: state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, shift in ALIGN, round/negate in FINISH.
  always_comb begin
    sign_d     = sign_q;
    mag_d      = mag_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    rem_d      = rem_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    spec_inv_d = spec_inv_q;
    res_d      = res_q;
    inv_d      = inv_q;
    inex_d     = inex_q;
    if (accept) begin
      sign_d     = in_data[31];
      mag_d      = dec_mag;
      guard_d    = 1'b0;
      sticky_d   = dec_sticky;
      rem_d      = dec_rem;
      spec_d     = dec_spec;
      spec_val_d = dec_val;
      spec_inv_d = dec_inv;
    end else if (state_q == StAlign) begin
      mag_d    = sh_mag;
      guard_d  = sh_guard;
      sticky_d = sh_sticky;
      rem_d    = rem_q - amt;
    end else if (state_q == StFinish) begin
      if (spec_q) begin
        res_d  = spec_val_q;
        inv_d  = spec_inv_q;
        inex_d = 1'b0;
      end else begin
        res_d  = sign_q ? (32'h0 - rnd_mag) : rnd_mag;
        inv_d  = 1'b0;
        inex_d = guard_q | sticky_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      mag_q      <= 32'h0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      rem_q      <= 5'd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'h0;
      spec_inv_q <= 1'b0;
      res_q      <= 32'h0;
      inv_q      <= 1'b0;
      inex_q     <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      rem_q      <= rem_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      spec_inv_q <= spec_inv_d;
      res_q      <= res_d;
      inv_q      <= inv_d;
      inex_q     <= inex_d;
    end
  end

  assign out_data    = res_q;
  assign out_invalid = inv_q;
  assign out_inexact = inex_q;

endmodule
